// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, registered active-low syncs
// and blanked colour outputs with a one-pixel renderer pipeline.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rgb_in,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [3:0] div_r;
  logic [9:0] hcount_r;
  logic [9:0] vcount_r;
  logic       hsync_r;
  logic       vsync_r;
  logic [2:0] red_r;
  logic [2:0] green_r;
  logic [1:0] blue_r;

  logic [3:0] div_next_s;
  logic [9:0] hcount_next_s;
  logic [9:0] vcount_next_s;
  logic       pix_tick_s;
  logic       frame_tick_s;
  logic       video_on_s;
  logic       hsync_raw_s;
  logic       vsync_raw_s;
  logic [2:0] red_next_s;
  logic [2:0] green_next_s;
  logic [1:0] blue_next_s;

  // Divider phase, tick qualifiers and sync/visibility decode of the current position.
  always_comb begin
    div_next_s   = 4'd0;
    pix_tick_s   = 1'b0;
    frame_tick_s = 1'b0;
    if (div_r == DIV_LAST) begin
      div_next_s = 4'd0;
    end else begin
      div_next_s = div_r + 4'd1;
    end
    // Ticks are suppressed for the whole reset window, whatever the divider phase.
    if (reset) begin
      pix_tick_s   = 1'b0;
      frame_tick_s = 1'b0;
    end else begin
      pix_tick_s   = (div_r == DIV_LAST);
      frame_tick_s = (div_r == DIV_LAST) && (hcount_r == H_LAST) && (vcount_r == V_LAST);
    end
    video_on_s  = (hcount_r < H_VIS) && (vcount_r < V_VIS);
    hsync_raw_s = !((hcount_r >= HS_FIRST) && (hcount_r <= HS_LAST));
    vsync_raw_s = !((vcount_r >= VS_FIRST) && (vcount_r <= VS_LAST));
  end

  // Next counter values and blanked colour, applied only on pixel ticks.
  always_comb begin
    hcount_next_s = hcount_r;
    vcount_next_s = vcount_r;
    if (hcount_r == H_LAST) begin
      hcount_next_s = 10'd0;
      if (vcount_r == V_LAST) begin
        vcount_next_s = 10'd0;
      end else begin
        vcount_next_s = vcount_r + 10'd1;
      end
    end else begin
      hcount_next_s = hcount_r + 10'd1;
      vcount_next_s = vcount_r;
    end
    if (video_on_s) begin
      red_next_s   = rgb_in[7:5];
      green_next_s = rgb_in[4:2];
      blue_next_s  = rgb_in[1:0];
    end else begin
      red_next_s   = 3'd0;
      green_next_s = 3'd0;
      blue_next_s  = 2'd0;
    end
  end

  // State and output registers; everything except the divider advances once per pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r    <= 4'd0;
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
      hsync_r  <= 1'b1;
      vsync_r  <= 1'b1;
      red_r    <= 3'd0;
      green_r  <= 3'd0;
      blue_r   <= 2'd0;
    end else begin
      div_r <= div_next_s;
      if (pix_tick_s) begin
        hcount_r <= hcount_next_s;
        vcount_r <= vcount_next_s;
        hsync_r  <= hsync_raw_s;
        vsync_r  <= vsync_raw_s;
        red_r    <= red_next_s;
        green_r  <= green_next_s;
        blue_r   <= blue_next_s;
      end
    end
  end

  assign hcount     = hcount_r;
  assign vcount     = vcount_r;
  assign video_on   = video_on_s;
  assign pix_tick   = pix_tick_s;
  assign frame_tick = frame_tick_s;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign red        = red_r;
  assign green      = green_r;
  assign blue       = blue_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so whole frames fit in a short run;
// expectations come from clock-count arithmetic over the timing rules.
module tb_vga_sync_gen;

  localparam int D  = 3;
  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HS0 = HV + HF, HS1 = HV + HF + HS - 1;
  localparam int VS0 = VV + VF, VS1 = VV + VF + VS - 1;
  localparam int FRAME = HT * VT * D;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rgb_in;
  logic [9:0] hcount, vcount;
  logic       video_on, pix_tick, frame_tick, hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;

  int         comps = 0;
  int         fails = 0;
  int         k = 0;
  int         last_ft = -1;
  int         rgb_mode = 0;
  logic [7:0] tick_rgb = 8'h00;

  vga_sync_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .pix_tick(pix_tick), .frame_tick(frame_tick),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic visible(input int p);
    return ((p % HT) < HV) && (((p / HT) % VT) < VV);
  endfunction

  // Compare every output against the position implied by k clocks since release.
  task automatic check_model();
    int p, hc, vc, prev;
    logic pt;
    logic [7:0] col;
    p  = k / D;
    hc = p % HT;
    vc = (p / HT) % VT;
    pt = ((k % D) == D - 1);
    chk("hcount", 32'(hcount), 32'(hc));
    chk("vcount", 32'(vcount), 32'(vc));
    chk("video_on", 32'(video_on), 32'((hc < HV) && (vc < VV)));
    chk("pix_tick", 32'(pix_tick), 32'(pt));
    chk("frame_tick", 32'(frame_tick), 32'(pt && hc == HT - 1 && vc == VT - 1));
    if (p == 0) begin
      chk("hsync", 32'(hsync), 32'd1);
      chk("vsync", 32'(vsync), 32'd1);
      col = 8'h00;
    end else begin
      prev = p - 1;
      chk("hsync", 32'(hsync), 32'(!((prev % HT) >= HS0 && (prev % HT) <= HS1)));
      chk("vsync", 32'(vsync), 32'(!(((prev / HT) % VT) >= VS0 && ((prev / HT) % VT) <= VS1)));
      col = visible(prev) ? tick_rgb : 8'h00;
    end
    chk("rgb", 32'({red, green, blue}), 32'(col));
    if (!hsync || !vsync) chk("rgb_in_sync", 32'({red, green, blue}), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      case (rgb_mode)
        0: rgb_in = 8'($urandom);
        1: rgb_in = 8'hFF;
        default: rgb_in = 8'((k / D) % HT);
      endcase
      if ((k % D) == D - 1) tick_rgb = rgb_in;
      @(posedge clk);
      @(negedge clk);
      k++;
      check_model();
      if (frame_tick) begin
        if (last_ft >= 0) chk("frame_period", 32'(k - last_ft), 32'(FRAME));
        else chk("first_frame_tick", 32'(k), 32'(FRAME - 1));
        last_ft = k;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    rgb_in = 8'($urandom);
    #1;
    chk("rst_pix_tick", 32'(pix_tick), 32'd0);
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hcount", 32'(hcount), 32'd0);
      chk("rst_vcount", 32'(vcount), 32'd0);
      chk("rst_hsync", 32'(hsync), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd1);
      chk("rst_rgb", 32'({red, green, blue}), 32'd0);
      chk("rst_video_on", 32'(video_on), 32'd1);
      chk("rst_pix_tick", 32'(pix_tick), 32'd0);
      chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    end
    reset = 1'b0;
    k = 0;
    last_ft = -1;
    #1;
    check_model();
  endtask

  initial begin
    int guard;
    reset  = 1'b1;
    rgb_in = 8'h00;
    @(negedge clk);
    do_reset(10);

    rgb_mode = 0;
    run(FRAME + 100);
    rgb_mode = 1;
    run(FRAME);
    rgb_mode = 2;
    run(FRAME / 2);

    // Reset mid-line while hsync is low, then expect a full frame from release.
    rgb_mode = 0;
    guard = 0;
    while (!(((k / D) % HT) == HS0 + 3 && (k % D) == 0) && guard < FRAME) begin
      run(1);
      guard++;
    end
    chk("midframe_found", 32'(guard < FRAME), 32'd1);
    chk("midframe_hsync_low", 32'(hsync), 32'd0);
    do_reset(1);
    run(FRAME + 50);
    chk("frame_after_reset_seen", 32'(last_ft), 32'(FRAME - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
